// File: rtl/jt49_cen_ctl_pkg.sv
// Shared definitions for the JT49 clock-enable controller: FSM state
// encodings, divider-mode constants and the cen8 boundary test.
package jt49_cen_defs;

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_t;

  localparam logic SEL_DIV8  = 1'b1;
  localparam logic SEL_DIV16 = 1'b0;

  // True when a cen issued at count ph starts a new cen8 period.
  function automatic logic div_boundary(input logic sel, input logic [3:0] ph);
    return (sel == SEL_DIV8) ? (ph[2:0] == 3'd0) : (ph == 4'd0);
  endfunction

endpackage

// File: rtl/jt49_cen_ctl_frac_acc.sv
// Fractional N/D accumulator. tick is the combinational "this step wraps"
// flag; the controller registers it as cen. acc stays below den, and with
// num <= den the sum fits in W+1 bits.
module jt49_frac_acc #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         run,
  input  logic [W-1:0] num,
  input  logic [W-1:0] den,
  output logic         tick
);

  logic [W-1:0] acc;
  logic [W:0]   sum;
  logic         hit;

  // Compare the next sum against den; only a running step can tick.
  always_comb begin
    sum  = {1'b0, acc} + {1'b0, num};
    hit  = (sum >= {1'b0, den});
    tick = run && hit;
  end

  // Accumulate while running; clr wins so a ratio change restarts from 0.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc <= '0;
    end else if (run) begin
      acc <= hit ? W'(sum - {1'b0, den}) : sum[W-1:0];
    end
  end

endmodule

// File: rtl/jt49_cen_ctl.sv
// Programmable clock-enable controller for the JT49 PSG. Produces cen at
// an average rate of clk*num/den and cen8 every 8 or 16 cen pulses.
// Ratio/mode changes made while running wait in a shadow register and are
// applied on a cen8 boundary so no generator period is cut short.
//
// Config port: a word transfers on a rising edge where cfg_valid and
// cfg_ready are both 1. cfg_ready is registered and low only while a
// shadow word is waiting. Every transferred word is consumed; an invalid
// one (num==0, den==0 or num>den) is dropped and flagged by a one-cycle
// cfg_err pulse in the cycle after the transfer.
module jt49_cen_ctl
  import jt49_cen_defs::*;
#(
  parameter int          W       = 16,
  parameter int unsigned DEF_NUM = 1,
  parameter int unsigned DEF_DEN = 2,
  parameter bit          DEF_SEL = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic         cfg_valid,
  output logic         cfg_ready,
  input  logic [W-1:0] cfg_num,
  input  logic [W-1:0] cfg_den,
  input  logic         cfg_sel,
  output logic         cfg_err,
  output logic         cen,
  output logic         cen8,
  output logic [3:0]   phase
);

  state_t       state;
  logic [W-1:0] num_r, den_r, sh_num, sh_den;
  logic         sel_r, sh_sel;

  logic         tick;
  logic         acc_run, acc_clr;
  logic         accept, word_ok;
  logic [3:0]   pc_next;
  logic         div_hit;

  // Handshake decode, phase look-ahead and accumulator control.
  always_comb begin
    accept  = cfg_valid && cfg_ready;
    word_ok = (cfg_num != '0) && (cfg_den != '0) && (cfg_num <= cfg_den);
    // phase shows the count for the current cen; it advances after it.
    pc_next = phase + {3'b000, cen};
    div_hit = tick && div_boundary(sel_r, pc_next);
    acc_run = (state != ST_STOP) && enable;
    acc_clr = (state == ST_STOP) || !enable || ((state == ST_PEND) && div_hit);
  end

  jt49_frac_acc #(.W(W)) u_acc (
    .clk  (clk),
    .rst  (rst),
    .clr  (acc_clr),
    .run  (acc_run),
    .num  (num_r),
    .den  (den_r),
    .tick (tick)
  );

  // Control FSM with registered strobes, phase, handshake and error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_STOP;
      num_r     <= W'(DEF_NUM);
      den_r     <= W'(DEF_DEN);
      sel_r     <= DEF_SEL;
      sh_num    <= '0;
      sh_den    <= '0;
      sh_sel    <= 1'b0;
      cen       <= 1'b0;
      cen8      <= 1'b0;
      phase     <= 4'd0;
      cfg_ready <= 1'b1;
      cfg_err   <= 1'b0;
    end else begin
      cfg_err <= accept && !word_ok;
      case (state)
        ST_STOP: begin
          cen       <= 1'b0;
          cen8      <= 1'b0;
          phase     <= 4'd0;
          cfg_ready <= 1'b1;
          if (accept && word_ok) begin
            num_r <= cfg_num;
            den_r <= cfg_den;
            sel_r <= cfg_sel;
          end
          if (enable) state <= ST_RUN;
        end
        ST_RUN: begin
          if (!enable) begin
            state     <= ST_STOP;
            cen       <= 1'b0;
            cen8      <= 1'b0;
            phase     <= 4'd0;
            cfg_ready <= 1'b1;
            // Stopping: nothing to wait for, so a new word lands directly.
            if (accept && word_ok) begin
              num_r <= cfg_num;
              den_r <= cfg_den;
              sel_r <= cfg_sel;
            end
          end else begin
            cen   <= tick;
            cen8  <= div_hit;
            phase <= pc_next;
            if (accept && word_ok) begin
              sh_num    <= cfg_num;
              sh_den    <= cfg_den;
              sh_sel    <= cfg_sel;
              state     <= ST_PEND;
              cfg_ready <= 1'b0;
            end else begin
              cfg_ready <= 1'b1;
            end
          end
        end
        ST_PEND: begin
          if (!enable) begin
            state     <= ST_STOP;
            num_r     <= sh_num;
            den_r     <= sh_den;
            sel_r     <= sh_sel;
            cen       <= 1'b0;
            cen8      <= 1'b0;
            phase     <= 4'd0;
            cfg_ready <= 1'b1;
          end else begin
            cen  <= tick;
            cen8 <= div_hit;
            if (div_hit) begin
              // This cen8 closes the old period and opens the new one.
              num_r     <= sh_num;
              den_r     <= sh_den;
              sel_r     <= sh_sel;
              phase     <= 4'd0;
              state     <= ST_RUN;
              cfg_ready <= 1'b1;
            end else begin
              phase     <= pc_next;
              cfg_ready <= 1'b0;
            end
          end
        end
        default: begin
          state     <= ST_STOP;
          cen       <= 1'b0;
          cen8      <= 1'b0;
          phase     <= 4'd0;
          cfg_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jt49_cen_ctl.sv
// Bench for jt49_cen_ctl: table of ratio runs checked cycle by cycle
// against a closed-form cen/cen8/phase model, plus hand-written sequences
// for mid-run changes, invalid words, disable and reset while pending.
module tb_jt49_cen_ctl;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst, enable, cfg_valid, cfg_sel;
  logic [W-1:0] cfg_num, cfg_den;
  logic         cfg_ready, cfg_err, cen, cen8;
  logic [3:0]   phase;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [5:0] exp_q[$];

  typedef struct {
    bit          use_cfg;
    logic [15:0] num;
    logic [15:0] den;
    logic        sel;
    int          cycles;
    int          exp_cens;
    int          exp_cen8s;
  } vec_t;

  vec_t vecs[5];

  // Clock / reset block
  always #5 clk = ~clk;

  jt49_cen_ctl #(.W(W), .DEF_NUM(1), .DEF_DEN(2), .DEF_SEL(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_num   (cfg_num),
    .cfg_den   (cfg_den),
    .cfg_sel   (cfg_sel),
    .cfg_err   (cfg_err),
    .cen       (cen),
    .cen8      (cen8),
    .phase     (phase)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_cen"}, cen, 0);
    check({tag, "_cen8"}, cen8, 0);
    check({tag, "_phase"}, phase, 0);
    check({tag, "_ready"}, cfg_ready, 1);
    check({tag, "_err"}, cfg_err, 0);
  endtask

  task automatic send_cfg(input logic [W-1:0] n, input logic [W-1:0] d, input logic s);
    cfg_valid = 1'b1;
    cfg_num   = n;
    cfg_den   = d;
    cfg_sel   = s;
    step();
    cfg_valid = 1'b0;
  endtask

  // Scoreboard: call right after the enable edge. Step k after it carries
  // floor(k*n/d) total cen pulses; cen fires when that count steps up.
  task automatic run_model(input longint n, input longint d, input logic sel,
                           input int cycles, output int cens, output int cen8s);
    cens  = 0;
    cen8s = 0;
    for (int k = 1; k <= cycles; k++) begin
      longint     prev, cur;
      logic       ec, e8;
      logic [3:0] ep;
      logic [5:0] e;
      prev = ((k - 1) * n) / d;
      cur  = (k * n) / d;
      ec   = (cur != prev);
      ep   = 4'(prev % 16);
      e8   = ec && (sel ? ((prev % 8) == 0) : ((prev % 16) == 0));
      exp_q.push_back({ec, e8, ep});
      step();
      e = exp_q.pop_front();
      check($sformatf("sb_n%0d_d%0d_k%0d", n, d, k), {cen, cen8, phase}, e);
      if (cen) cens++;
      if (cen8) cen8s++;
    end
  endtask

  initial begin
    int found, t0, t1, t2, t3, ready_bad, lastc, min_gap, max_gap, ncen, c, c8;

    vecs[0] = '{0, 16'd1, 16'd2, 1'b1, 64, 32, 4};
    vecs[1] = '{1, 16'd3, 16'd8, 1'b0, 10000, 3750, 235};
    vecs[2] = '{1, 16'd1, 16'd1, 1'b1, 40, 40, 5};
    vecs[3] = '{1, 16'd5, 16'd7, 1'b0, 100, 71, 5};
    vecs[4] = '{1, 16'd1, 16'd4, 1'b0, 200, 50, 4};

    rst = 1'b1; enable = 1'b0; cfg_valid = 1'b0;
    cfg_num = '0; cfg_den = '0; cfg_sel = 1'b0;
    step();

    // Table-driven ratio runs; configured entries offer the word on the
    // same edge that enable rises.
    for (int i = 0; i < 5; i++) begin
      rst = 1'b1; enable = 1'b0;
      step();
      rst = 1'b0;
      check_idle($sformatf("v%0d_reset", i));
      enable = 1'b1;
      if (vecs[i].use_cfg) send_cfg(vecs[i].num, vecs[i].den, vecs[i].sel);
      else step();
      check($sformatf("v%0d_start_cen", i), cen, 0);
      run_model(vecs[i].num, vecs[i].den, vecs[i].sel, vecs[i].cycles, c, c8);
      check($sformatf("v%0d_cen_count", i), c, vecs[i].exp_cens);
      check($sformatf("v%0d_cen8_count", i), c8, vecs[i].exp_cen8s);
    end

    // Mid-run change: 1/2 div8 -> 1/4 div16 written at phase 3.
    rst = 1'b1; enable = 1'b0;
    step();
    rst = 1'b0; enable = 1'b1;
    step();
    found = 0; t0 = -1000; t3 = 0;
    for (int i = 0; i < 60 && found == 0; i++) begin
      step();
      if (cen8) t0 = cyc;
      if (cen && phase == 4'd3) begin found = 1; t3 = cyc; end
    end
    check("mid_phase3_found", found, 1);
    check("mid_cen8_to_phase3", t3 - t0, 6);
    send_cfg(16'd1, 16'd4, 1'b0);
    check("mid_ready_low", cfg_ready, 0);
    found = 0; ready_bad = 0; t1 = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      step();
      if (cen8) begin found = 1; t1 = cyc; end
      else if (cfg_ready) ready_bad++;
    end
    check("mid_apply_seen", found, 1);
    check("mid_ready_low_while_pend", ready_bad, 0);
    check("mid_old_cen8_period", t1 - t0, 16);
    check("mid_ready_back", cfg_ready, 1);
    check("mid_apply_phase", phase, 0);
    found = 0; lastc = t1; min_gap = 1000; max_gap = 0; ncen = 0; t2 = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      step();
      if (cen) begin
        if (cyc - lastc < min_gap) min_gap = cyc - lastc;
        if (cyc - lastc > max_gap) max_gap = cyc - lastc;
        lastc = cyc;
        ncen++;
      end
      if (cen8) begin found = 1; t2 = cyc; end
    end
    check("mid_new_cen8_seen", found, 1);
    check("mid_new_min_gap", min_gap, 4);
    check("mid_new_max_gap", max_gap, 4);
    check("mid_new_cen8_period", t2 - t1, 64);
    check("mid_new_cens_per_cen8", ncen, 16);

    // Invalid words while running at 1/4.
    send_cfg(16'd5, 16'd4, 1'b1);
    check("inv1_err", cfg_err, 1);
    check("inv1_ready", cfg_ready, 1);
    step();
    check("inv1_err_clear", cfg_err, 0);
    send_cfg(16'd0, 16'd4, 1'b1);
    check("inv2_err", cfg_err, 1);
    check("inv2_ready", cfg_ready, 1);
    step();
    check("inv2_err_clear", cfg_err, 0);
    lastc = -1; min_gap = 1000; max_gap = 0; ncen = 0; ready_bad = 0;
    for (int i = 0; i < 40 && ncen < 3; i++) begin
      step();
      if (!cfg_ready || cfg_err) ready_bad++;
      if (cen) begin
        if (lastc >= 0) begin
          if (cyc - lastc < min_gap) min_gap = cyc - lastc;
          if (cyc - lastc > max_gap) max_gap = cyc - lastc;
        end
        lastc = cyc;
        ncen++;
      end
    end
    check("inv_cens_seen", ncen, 3);
    check("inv_ratio_min_gap", min_gap, 4);
    check("inv_ratio_max_gap", max_gap, 4);
    check("inv_ready_steady", ready_bad, 0);

    // Disable while a 1/2 div8 word is pending.
    send_cfg(16'd1, 16'd2, 1'b1);
    check("dis_pend_ready", cfg_ready, 0);
    enable = 1'b0;
    step();
    check_idle("dis_stop");
    step();
    step();
    check("dis_still_cen", cen, 0);
    enable = 1'b1;
    step();
    run_model(1, 2, 1'b1, 48, c, c8);
    check("dis_reen_cens", c, 24);
    check("dis_reen_cen8s", c8, 3);

    // Reset while a 3/8 div16 word is pending: defaults must come back.
    send_cfg(16'd3, 16'd8, 1'b0);
    check("rstp_ready", cfg_ready, 0);
    rst = 1'b1;
    step();
    check_idle("rstp");
    rst = 1'b0;
    step();
    run_model(1, 2, 1'b1, 32, c, c8);
    check("rstp_def_cens", c, 16);
    check("rstp_def_cen8s", c8, 2);

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
